rns16_sched: RTL and testbench
==============================

// Module: rns16_sched
// PURPOSE
//  Shares one rns16 pipeline (8-bit in stream LSB→MSB, 16-bit out, result = word+2 mod 2^16) among N_REQ clients.
//  Round-robin grants 16-bit client words, serializes each into two bytes toward rns16, tags every in-flight word,
//  and routes each rns16 result back to the client that issued it. Sits between client ports and a single rns16.
// PARAMETERS
//  N_REQ      4   number of requesting clients (2..8)
//  TAG_DEPTH  8   max words in flight inside rns16 (power of 2, >=2); depth of tag FIFO
// PORTS
//  clk            in   1            clock, single domain
//  rst_n          in   1            reset, synchronous, active-low
//  req_word       in   N_REQ*16     client i word at [16*i+:16]
//  req_valid      in   N_REQ        client i has a word
//  req_ready      out  N_REQ        one-hot grant; word i taken when req_valid[i]&req_ready[i]
//  rsp_word       out  16           result word, shared by all clients
//  rsp_valid      out  N_REQ        one-hot: result belongs to client i
//  rsp_ready      in   N_REQ        client i accepts result
//  rns_in_byte    out  8            byte toward rns16
//  rns_in_valid   out  1
//  rns_in_ready   in   1
//  rns_out_word   in   16           result from rns16
//  rns_out_valid  in   1
//  rns_out_ready  out  1
//  inflight       out  $clog2(TAG_DEPTH)+1   tags currently reserved
//  err_orphan     out  1            sticky: rns16 produced a result with no tag outstanding
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, rr pointer=0, tag FIFO empty, inflight=0, err_orphan=0;
//   req_ready=0, rns_in_valid=0, rns_in_byte=0, rsp_valid=0, rsp_word=0, rns_out_ready=0. Reset mid-word drops
//   the partial word and all tags; behaviour of rns16 is its own reset's concern.
//  Issue FSM (registered outputs): IDLE -> LSB -> MSB -> IDLE.
//   IDLE: if any req_valid and inflight<TAG_DEPTH, grant = first valid index at/after rr pointer (wrapping);
//    req_ready[grant]=1 for exactly that cycle (combinational from registered state + req_valid);
//    at the edge: latch word, push tag=grant, rr pointer=grant+1 mod N_REQ, go LSB. Else stay, req_ready=0.
//   LSB: rns_in_valid=1, rns_in_byte=word[7:0]; on rns_in_ready -> MSB.
//   MSB: rns_in_valid=1, rns_in_byte=word[15:8]; on rns_in_ready -> IDLE.
//   Min spacing 3 cycles/word; bytes held stable while rns_in_ready=0.
//  Tag reserved at grant (not at MSB) so inflight never exceeds TAG_DEPTH; inflight==TAG_DEPTH blocks grants.
//  Return path (combinational): head tag h; rsp_valid[h]=rns_out_valid & !empty; rsp_word=rns_out_word;
//   rns_out_ready=rsp_ready[h] & !empty. Pop on rns_out_valid&rns_out_ready. rns16 is in-order: head matches.
//  Empty FIFO with rns_out_valid=1: rns_out_ready=1 (discard), rsp_valid=0, err_orphan<=1 until reset.
//  Push and pop in same cycle: inflight unchanged, both take effect.
//  Clients must not rely on any data arithmetic here; scheduler never modifies words.
// STRUCTURE
//  Shared package rns16_pkg: BYTE_W=8, WORD_W=16, issue-state encoding (IDLE/LSB/MSB), tag width function.
//  Sub-module rns16_tag_fifo (sync FIFO, width $clog2(N_REQ), depth TAG_DEPTH, count output, push/pop same
//   cycle legal). Round-robin picker and FSM stay in rns16_sched.
// TESTING (bench instantiates rns16_sched + rns16, per-client expected queues of word+2)
//  Single client 0 sends 0x00FF -> bytes 0xFF then 0x00 on rns side; rsp_valid=0001, rsp_word=0x0101.
//  All 4 clients valid constantly, words 0x1000+i -> grant order 0,1,2,3,0,...; each client gets 0x1002+i in order.
//  Client 2 word 0xFFFF -> rsp_word 0x0001 to client 2 only (wrap).
//  rsp_ready=0 for client 1 holding head -> after TAG_DEPTH=8 grants req_ready stays 0, inflight=8; release -> drains.
//  rns_in_ready toggled 50% random, 1000 words -> no byte lost/duplicated, all results routed correctly.
//  Reset asserted while FSM in MSB -> next cycle all outputs 0, inflight=0; fresh word 0x1234 -> 0x1236.

Source files
------------

// File: rtl/rns16_pkg.sv
// Shared constants, issue-FSM encoding and tag sizing for the rns16 scheduler slice.
package rns16_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LSB  = 2'd1,
    ST_MSB  = 2'd2
  } issue_state_e;

  // A tag names a client, so it needs just enough bits to index N_REQ clients.
  function automatic int tag_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/rns16_sched_if.sv
// Client-side bus of the scheduler: request words in, tagged results out.
interface rns16_sched_if
  import rns16_pkg::*;
#(
  parameter int N_REQ = 4
) ();

  logic [N_REQ*WORD_W-1:0] req_word;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [WORD_W-1:0]       rsp_word;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;

  modport master (
    output req_word, req_valid, rsp_ready,
    input  req_ready, rsp_word, rsp_valid
  );

  modport slave (
    input  req_word, req_valid, rsp_ready,
    output req_ready, rsp_word, rsp_valid
  );

endinterface

// File: rtl/rns16_tag_fifo.sv
// Synchronous tag FIFO recording which client owns each word inside rns16.
// Push and pop in the same cycle are both honoured and leave the count unchanged.
module rns16_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [W-1:0]           push_data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           head_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          push_ok_s, pop_ok_s;

  always_comb begin
    pop_ok_s  = pop_i && (count_q != '0);
    push_ok_s = push_i && ((count_q != (PW+1)'(DEPTH)) || pop_ok_s);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through the reset pointers.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign count_o = count_q;

endmodule

// File: rtl/rns16_sched.sv
// Round-robin scheduler sharing one rns16 among N_REQ clients: serializes granted words
// into LSB/MSB bytes, tags each word at grant, and steers in-order results back by tag.
module rns16_sched
  import rns16_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int TAG_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  rns16_sched_if.slave               cli,
  output logic [BYTE_W-1:0]          rns_in_byte,
  output logic                       rns_in_valid,
  input  logic                       rns_in_ready,
  input  logic [WORD_W-1:0]          rns_out_word,
  input  logic                       rns_out_valid,
  output logic                       rns_out_ready,
  output logic [$clog2(TAG_DEPTH):0] inflight,
  output logic                       err_orphan
);

  localparam int TAG_W = tag_width(N_REQ);

  issue_state_e      state_q, state_d;
  logic [TAG_W-1:0]  rr_q, rr_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              in_valid_q, in_valid_d;
  logic              err_q, err_d;

  logic              found_s, grant_en_s, push_s, pop_s, empty_s, full_s;
  logic [TAG_W-1:0]  grant_idx_s, head_s;
  logic [N_REQ-1:0]  req_ready_s, rsp_valid_s;
  logic              out_ready_s;
  int                idx_s;

  // Round-robin pick: first valid client at or after the pointer, wrapping.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = '0;
    idx_s       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_s = (int'(rr_q) + k >= N_REQ) ? int'(rr_q) + k - N_REQ : int'(rr_q) + k;
      if (!found_s && cli.req_valid[TAG_W'(idx_s)]) begin
        found_s     = 1'b1;
        grant_idx_s = TAG_W'(idx_s);
      end else begin
        found_s     = found_s;
      end
    end
  end

  // Grant only from IDLE with a free tag; reserving the tag here bounds inflight.
  always_comb begin
    grant_en_s  = rst_n && (state_q == ST_IDLE) && found_s && !full_s;
    req_ready_s = '0;
    if (grant_en_s) begin
      req_ready_s[grant_idx_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  // Issue FSM next state, plus the registered byte-side outputs for that state.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    word_d     = word_q;
    push_s     = 1'b0;
    in_valid_d = 1'b0;
    byte_d     = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_en_s) begin
          word_d  = cli.req_word[int'(grant_idx_s)*WORD_W +: WORD_W];
          push_s  = 1'b1;
          rr_d    = (grant_idx_s == TAG_W'(N_REQ - 1)) ? '0 : grant_idx_s + TAG_W'(1);
          state_d = ST_LSB;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LSB: begin
        if (rns_in_ready) state_d = ST_MSB;
        else              state_d = ST_LSB;
      end
      ST_MSB: begin
        if (rns_in_ready) state_d = ST_IDLE;
        else              state_d = ST_MSB;
      end
      default: state_d = ST_IDLE;
    endcase
    case (state_d)
      ST_LSB: begin
        in_valid_d = 1'b1;
        byte_d     = word_d[BYTE_W-1:0];
      end
      ST_MSB: begin
        in_valid_d = 1'b1;
        byte_d     = word_d[WORD_W-1:BYTE_W];
      end
      default: begin
        in_valid_d = 1'b0;
        byte_d     = '0;
      end
    endcase
  end

  // Return path: head tag routes the result; with no tag outstanding the result is discarded.
  always_comb begin
    rsp_valid_s = '0;
    out_ready_s = 1'b0;
    if (!rst_n) begin
      out_ready_s = 1'b0;
    end else if (!empty_s) begin
      rsp_valid_s[head_s] = rns_out_valid;
      out_ready_s         = cli.rsp_ready[head_s];
    end else begin
      out_ready_s = rns_out_valid;
    end
    pop_s = rns_out_valid && out_ready_s && !empty_s;
    err_d = err_q || (rst_n && rns_out_valid && empty_s);
  end

  // State and registered outputs; reset drops any partially issued word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_q       <= '0;
      word_q     <= '0;
      byte_q     <= '0;
      in_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      word_q     <= word_d;
      byte_q     <= byte_d;
      in_valid_q <= in_valid_d;
      err_q      <= err_d;
    end
  end

  rns16_tag_fifo #(
    .W     (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tags (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_s),
    .push_data_i (grant_idx_s),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .empty_o     (empty_s),
    .full_o      (full_s),
    .count_o     (inflight)
  );

  assign cli.req_ready = req_ready_s;
  assign cli.rsp_valid = rsp_valid_s;
  assign cli.rsp_word  = rns_out_word;
  assign rns_out_ready = out_ready_s;
  assign rns_in_valid  = in_valid_q;
  assign rns_in_byte   = byte_q;
  assign err_orphan    = err_q;

endmodule

// File: tb/tb_rns16_sched.sv
// Directed bench for rns16_sched with a behavioural rns16 (two bytes in, word+2 out, in order).
module tb_rns16_sched;
  import rns16_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rns_in_byte;
  logic        rns_in_valid;
  logic        rns_in_ready = 1'b0;
  logic [15:0] rns_out_word = 16'h0000;
  logic        rns_out_valid = 1'b0;
  logic        rns_out_ready;
  logic [3:0]  inflight;
  logic        err_orphan;

  rns16_sched_if #(.N_REQ(N)) bus ();

  rns16_sched #(.N_REQ(N), .TAG_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cli           (bus),
    .rns_in_byte   (rns_in_byte),
    .rns_in_valid  (rns_in_valid),
    .rns_in_ready  (rns_in_ready),
    .rns_out_word  (rns_out_word),
    .rns_out_valid (rns_out_valid),
    .rns_out_ready (rns_out_ready),
    .inflight      (inflight),
    .err_orphan    (err_orphan)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] send_q [N][$];
  logic [15:0] exp_q [N][$];
  int          grant_log [$];
  logic [3:0]  rsp_vec_log [$];
  logic [15:0] rsp_word_log [$];
  logic [7:0]  byte_log [$];
  logic [15:0] res_q [$];
  logic [7:0]  lsb_m;
  bit          have_lsb_m = 1'b0;
  logic [15:0] tmp_w;
  logic [3:0]  rsp_rdy_mask = 4'hF;
  bit          rand_mode = 1'b0;
  bit          rin_fixed = 1'b1;

  // Client and rns-side stimulus, applied on the falling edge
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (send_q[i].size() > 0) begin
        bus.req_valid[i] = 1'b1;
        bus.req_word[16*i +: 16] = send_q[i][0];
      end else begin
        bus.req_valid[i] = 1'b0;
        bus.req_word[16*i +: 16] = 16'h0000;
      end
    end
    bus.rsp_ready = rsp_rdy_mask;
    rns_in_ready = rand_mode ? 1'($urandom_range(0, 1)) : rin_fixed;
  end

  // Handshake logging plus the rns16 behavioural model
  always @(posedge clk) begin
    if (!rst_n) begin
      have_lsb_m = 1'b0;
      res_q.delete();
      rns_out_valid <= 1'b0;
      rns_out_word  <= 16'h0000;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i] && send_q[i].size() > 0) begin
          grant_log.push_back(i);
          tmp_w = send_q[i].pop_front();
        end
      end
      if ((bus.rsp_valid & bus.rsp_ready) != 4'h0) begin
        rsp_vec_log.push_back(bus.rsp_valid);
        rsp_word_log.push_back(bus.rsp_word);
      end
      if (rns_out_valid && rns_out_ready && res_q.size() > 0) tmp_w = res_q.pop_front();
      if (rns_in_valid && rns_in_ready) begin
        byte_log.push_back(rns_in_byte);
        if (have_lsb_m) begin
          tmp_w = {rns_in_byte, lsb_m};
          res_q.push_back(tmp_w + 16'd2);
          have_lsb_m = 1'b0;
        end else begin
          lsb_m = rns_in_byte;
          have_lsb_m = 1'b1;
        end
      end
      rns_out_valid <= (res_q.size() > 0);
      rns_out_word  <= (res_q.size() > 0) ? res_q[0] : 16'h0000;
    end
  end

  task automatic clear_logs();
    for (int i = 0; i < N; i++) begin
      send_q[i].delete();
      exp_q[i].delete();
    end
    grant_log.delete();
    rsp_vec_log.delete();
    rsp_word_log.delete();
    byte_log.delete();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    clear_logs();
    rsp_rdy_mask = 4'hF;
    rand_mode = 1'b0;
    rin_fixed = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_rsp(input int n, input int limit, output bit ok);
    int c = 0;
    while (rsp_word_log.size() < n && c < limit) begin
      @(negedge clk);
      c++;
    end
    ok = (rsp_word_log.size() >= n);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_logs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
    n_cmp++; if (rns_in_valid !== 1'b0) begin n_fail++; $display("FAIL reset_in_valid: got %b want 0", rns_in_valid); end
    n_cmp++; if (rns_in_byte !== 8'h00) begin n_fail++; $display("FAIL reset_in_byte: got %h want 00", rns_in_byte); end
    n_cmp++; if (bus.rsp_valid !== 4'h0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0000", bus.rsp_valid); end
    n_cmp++; if (rns_out_ready !== 1'b0) begin n_fail++; $display("FAIL reset_out_ready: got %b want 0", rns_out_ready); end
    n_cmp++; if (inflight !== 4'd0) begin n_fail++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
    n_cmp++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_orphan); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    reset_dut();
    send_q[0].push_back(16'h00FF);
    wait_rsp(1, 50, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got %0d responses want 1", rsp_word_log.size()); end
    if (ok) begin
      n_cmp++; if (byte_log.size() != 2 || byte_log[0] !== 8'hFF || byte_log[1] !== 8'h00) begin
        n_fail++; $display("FAIL single_bytes: got %p want FF,00", byte_log);
      end
      n_cmp++; if (rsp_vec_log[0] !== 4'b0001) begin n_fail++; $display("FAIL single_vec: got %b want 0001", rsp_vec_log[0]); end
      n_cmp++; if (rsp_word_log[0] !== 16'h0101) begin n_fail++; $display("FAIL single_word: got %h want 0101", rsp_word_log[0]); end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    reset_dut();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) send_q[i].push_back(16'h1000 + 16'(i));
    wait_rsp(12, 200, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL rr_timeout: got %0d responses want 12", rsp_word_log.size()); end
    if (ok) begin
      for (int k = 0; k < 12; k++) begin
        n_cmp++; if (grant_log[k] != k % 4) begin n_fail++; $display("FAIL rr_grant[%0d]: got %0d want %0d", k, grant_log[k], k % 4); end
        n_cmp++; if (rsp_vec_log[k] !== 4'(1 << (k % 4)) || rsp_word_log[k] !== 16'h1002 + 16'(k % 4)) begin
          n_fail++; $display("FAIL rr_rsp[%0d]: got %b/%h want %b/%h", k, rsp_vec_log[k], rsp_word_log[k], 4'(1 << (k % 4)), 16'h1002 + 16'(k % 4));
        end
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    reset_dut();
    send_q[2].push_back(16'hFFFF);
    wait_rsp(1, 50, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL wrap_timeout: got %0d responses want 1", rsp_word_log.size()); end
    if (ok) begin
      n_cmp++; if (rsp_vec_log[0] !== 4'b0100 || rsp_word_log[0] !== 16'h0001) begin
        n_fail++; $display("FAIL wrap_rsp: got %b/%h want 0100/0001", rsp_vec_log[0], rsp_word_log[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    reset_dut();
    rsp_rdy_mask = 4'b1101;
    for (int k = 0; k < 9; k++) send_q[1].push_back(16'h2000 + 16'(k));
    repeat (60) @(negedge clk);
    n_cmp++; if (grant_log.size() != 8) begin n_fail++; $display("FAIL bp_grants: got %0d want 8", grant_log.size()); end
    n_cmp++; if (inflight !== 4'd8) begin n_fail++; $display("FAIL bp_inflight: got %0d want 8", inflight); end
    n_cmp++; if (bus.req_ready !== 4'h0) begin n_fail++; $display("FAIL bp_req_ready: got %b want 0000", bus.req_ready); end
    n_cmp++; if (bus.rsp_valid !== 4'b0010 || rns_out_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_head_held: got %b/%b want 0010/0", bus.rsp_valid, rns_out_ready);
    end
    n_cmp++; if (rsp_word_log.size() != 0) begin n_fail++; $display("FAIL bp_no_rsp: got %0d want 0", rsp_word_log.size()); end
    rsp_rdy_mask = 4'hF;
    wait_rsp(9, 200, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL bp_drain_timeout: got %0d responses want 9", rsp_word_log.size()); end
    if (ok) begin
      for (int k = 0; k < 9; k++) begin
        n_cmp++; if (rsp_vec_log[k] !== 4'b0010 || rsp_word_log[k] !== 16'h2002 + 16'(k)) begin
          n_fail++; $display("FAIL bp_rsp[%0d]: got %b/%h want 0010/%h", k, rsp_vec_log[k], rsp_word_log[k], 16'h2002 + 16'(k));
        end
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++; if (inflight !== 4'd0) begin n_fail++; $display("FAIL bp_final_inflight: got %0d want 0", inflight); end
  endtask

  task automatic test_random_ready();
    bit          ok;
    logic [15:0] w;
    logic [3:0]  v;
    int          c;
    reset_dut();
    for (int k = 0; k < 250; k++)
      for (int i = 0; i < N; i++) begin
        w = 16'($urandom);
        send_q[i].push_back(w);
        exp_q[i].push_back(w + 16'd2);
      end
    rand_mode = 1'b1;
    wait_rsp(1000, 30000, ok);
    rand_mode = 1'b0;
    rin_fixed = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL rand_timeout: got %0d responses want 1000", rsp_word_log.size()); end
    n_cmp++; if (byte_log.size() != 2000) begin n_fail++; $display("FAIL rand_bytes: got %0d want 2000", byte_log.size()); end
    for (int j = 0; j < rsp_word_log.size(); j++) begin
      v = rsp_vec_log[j];
      c = 0;
      for (int i = 0; i < N; i++) if (v[i]) c = i;
      n_cmp++;
      if ($countones(v) != 1 || exp_q[c].size() == 0) begin
        n_fail++; $display("FAIL rand_route[%0d]: got vec %b, no result expected there", j, v);
      end else begin
        w = exp_q[c].pop_front();
        if (rsp_word_log[j] !== w) begin
          n_fail++; $display("FAIL rand_word[%0d]: got %h want %h (client %0d)", j, rsp_word_log[j], w, c);
        end
      end
    end
  endtask

  task automatic test_orphan();
    @(negedge clk);
    rsp_vec_log.delete();
    rsp_word_log.delete();
    res_q.push_back(16'hDEAD);
    repeat (4) @(negedge clk);
    n_cmp++; if (err_orphan !== 1'b1) begin n_fail++; $display("FAIL orphan_err: got %b want 1", err_orphan); end
    n_cmp++; if (res_q.size() != 0 || rsp_word_log.size() != 0) begin
      n_fail++; $display("FAIL orphan_discard: got %0d pending / %0d routed want 0/0", res_q.size(), rsp_word_log.size());
    end
  endtask

  task automatic test_reset_mid_word();
    bit ok;
    int c = 0;
    rin_fixed = 1'b0;
    clear_logs();
    send_q[3].push_back(16'hABCD);
    @(negedge clk);
    while (!rns_in_valid && c < 20) begin @(negedge clk); c++; end
    n_cmp++; if (rns_in_valid !== 1'b1 || rns_in_byte !== 8'hCD) begin
      n_fail++; $display("FAIL mid_lsb: got %b/%h want 1/CD", rns_in_valid, rns_in_byte);
    end
    @(posedge clk); #1 rin_fixed = 1'b1;
    @(posedge clk); #1 rin_fixed = 1'b0;
    @(negedge clk);
    n_cmp++; if (rns_in_valid !== 1'b1 || rns_in_byte !== 8'hAB) begin
      n_fail++; $display("FAIL mid_msb_hold: got %b/%h want 1/AB", rns_in_valid, rns_in_byte);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (rns_in_valid !== 1'b0 || rns_in_byte !== 8'h00 || bus.req_ready !== 4'h0) begin
      n_fail++; $display("FAIL mid_rst_issue: got %b/%h/%b want 0/00/0000", rns_in_valid, rns_in_byte, bus.req_ready);
    end
    n_cmp++; if (bus.rsp_valid !== 4'h0 || rns_out_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_return: got %b/%b want 0000/0", bus.rsp_valid, rns_out_ready);
    end
    n_cmp++; if (inflight !== 4'd0 || err_orphan !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_state: got %0d/%b want 0/0", inflight, err_orphan);
    end
    rst_n = 1'b1;
    rin_fixed = 1'b1;
    clear_logs();
    send_q[0].push_back(16'h1234);
    wait_rsp(1, 50, ok);
    n_cmp++; if (!ok || rsp_vec_log[0] !== 4'b0001 || rsp_word_log[0] !== 16'h1236) begin
      n_fail++; $display("FAIL mid_fresh: got %0d rsp, %h want 1 rsp to 0001, 1236", rsp_word_log.size(), ok ? rsp_word_log[0] : 16'h0000);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_random_ready();
    test_orphan();
    test_reset_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
